// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter: count controls in, registered count and flags out.
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, clr, load, load_val,
    input  out, tc, ovf
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output out, tc, ovf
  );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with clear/load, wrap-or-saturate, tc pulse and sticky ovf.
// Optional enable prescaler compiled in with `define COUNTER_PRESCALE_EN.
module param_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  param_updown_counter_if.slave  bus
);

  localparam int unsigned     MAX_I = MODULUS - 1;
  localparam logic [WIDTH-1:0] MAX  = MAX_I[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_fire;

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned PS_LAST_I = (PRESCALE > 0) ? PRESCALE - 1 : 0;
  localparam logic [PW-1:0] PS_LAST = PS_LAST_I[PW-1:0];

  logic [PW-1:0] ps_q, ps_d;

  always_comb begin
    ps_d = ps_q;
    if (bus.clr || bus.load) begin
      ps_d = '0;
    end else if (bus.en) begin
      ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  // With PRESCALE=1 PS_LAST is 0, so every enabled edge steps.
  assign step_fire = (ps_q == PS_LAST);
`else
  assign step_fire = 1'b1;
`endif

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      cnt_d = (bus.load_val <= MAX) ? bus.load_val : MAX;
    end else if (bus.en && step_fire) begin
      if (bus.up) begin
        if (cnt_q == MAX) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          cnt_d = (SATURATE != 0) ? MAX : '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          cnt_d = (SATURATE != 0) ? '0 : MAX;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: wrap (dut0) and saturate (dut1) counters, MODULUS=10, driven in lockstep.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  int         checks = 0;
  int         errors = 0;

  param_updown_counter_if #(.WIDTH(4)) bus0 ();
  param_updown_counter_if #(.WIDTH(4)) bus1 ();

  assign bus0.en = en;   assign bus1.en = en;
  assign bus0.up = up;   assign bus1.up = up;
  assign bus0.clr = clr; assign bus1.clr = clr;
  assign bus0.load = load; assign bus1.load = load;
  assign bus0.load_val = load_val; assign bus1.load_val = load_val;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({bus0.out, bus0.tc, bus0.ovf} !== 6'b0) begin
      errors++; $display("FAIL reset_wrap got %h/%b/%b want 0/0/0", bus0.out, bus0.tc, bus0.ovf);
    end
    checks++;
    if ({bus1.out, bus1.tc, bus1.ovf} !== 6'b0) begin
      errors++; $display("FAIL reset_sat got %h/%b/%b want 0/0/0", bus1.out, bus1.tc, bus1.ovf);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    logic [3:0] eo0, eo1;
    logic       etc, eovf;
    apply_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      eo0  = 4'(i % 10);
      eo1  = (i >= 9) ? 4'd9 : 4'(i);
      eovf = (i >= 10);
      etc  = (i == 10);
      checks++;
      if ({bus0.out, bus0.tc, bus0.ovf} !== {eo0, etc, eovf}) begin
        errors++; $display("FAIL up_wrap[%0d] got %h/%b/%b want %h/%b/%b", i, bus0.out, bus0.tc, bus0.ovf, eo0, etc, eovf);
      end
      etc = (i >= 10);
      checks++;
      if ({bus1.out, bus1.tc, bus1.ovf} !== {eo1, etc, eovf}) begin
        errors++; $display("FAIL up_sat[%0d] got %h/%b/%b want %h/%b/%b", i, bus1.out, bus1.tc, bus1.ovf, eo1, etc, eovf);
      end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] exp_o0 [3] = '{4'd9, 4'd8, 4'd7};
    logic       exp_t0 [3] = '{1'b1, 1'b0, 1'b0};
    apply_reset();
    en = 1'b1; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus0.out, bus0.tc, bus0.ovf} !== {exp_o0[i], exp_t0[i], 1'b1}) begin
        errors++; $display("FAIL down_wrap[%0d] got %h/%b/%b want %h/%b/1", i, bus0.out, bus0.tc, bus0.ovf, exp_o0[i], exp_t0[i]);
      end
      checks++;
      if ({bus1.out, bus1.tc, bus1.ovf} !== {4'd0, 1'b1, 1'b1}) begin
        errors++; $display("FAIL down_sat[%0d] got %h/%b/%b want 0/1/1", i, bus1.out, bus1.tc, bus1.ovf);
      end
    end
  endtask

  task automatic test_load_clr();
    // Continues from down-count state: ovf is already set in both counters.
    logic [3:0] lv   [4] = '{4'd7, 4'd14, 4'd3, 4'd0};
    logic       ld   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       cl   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       ens  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] eo   [4] = '{4'd7, 4'd9, 4'd0, 4'd0};
    logic       eovf [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      load_val = lv[i]; load = ld[i]; clr = cl[i]; en = ens[i]; up = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus0.out, bus0.tc, bus0.ovf} !== {eo[i], 1'b0, eovf[i]}) begin
        errors++; $display("FAIL load_wrap[%0d] got %h/%b/%b want %h/0/%b", i, bus0.out, bus0.tc, bus0.ovf, eo[i], eovf[i]);
      end
      checks++;
      if ({bus1.out, bus1.tc, bus1.ovf} !== {eo[i], 1'b0, eovf[i]}) begin
        errors++; $display("FAIL load_sat[%0d] got %h/%b/%b want %h/0/%b", i, bus1.out, bus1.tc, bus1.ovf, eo[i], eovf[i]);
      end
    end
    load = 1'b0; clr = 1'b0;
  endtask

  task automatic test_saturate();
    logic [3:0] eo0  [4] = '{4'd9, 4'd0, 4'd1, 4'd2};
    logic       et0  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       et1  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       eovf [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    clr = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0; load = 1'b1; load_val = 4'd8;
    @(posedge clk); #1;
    checks++;
    if ({bus1.out, bus1.tc, bus1.ovf} !== {4'd8, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sat_preload got %h/%b/%b want 8/0/0", bus1.out, bus1.tc, bus1.ovf);
    end
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus1.out, bus1.tc, bus1.ovf} !== {4'd9, et1[i], eovf[i]}) begin
        errors++; $display("FAIL sat_hold[%0d] got %h/%b/%b want 9/%b/%b", i, bus1.out, bus1.tc, bus1.ovf, et1[i], eovf[i]);
      end
      checks++;
      if ({bus0.out, bus0.tc, bus0.ovf} !== {eo0[i], et0[i], eovf[i]}) begin
        errors++; $display("FAIL sat_wrapref[%0d] got %h/%b/%b want %h/%b/%b", i, bus0.out, bus0.tc, bus0.ovf, eo0[i], et0[i], eovf[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; en = 1'b1; up = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus0.out !== 4'd5) begin
      errors++; $display("FAIL arst_pre got %h want 5", bus0.out);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus0.out, bus0.tc, bus0.ovf} !== 6'b0) begin
      errors++; $display("FAIL arst_mid got %h/%b/%b want 0/0/0", bus0.out, bus0.tc, bus0.ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus0.out, bus0.tc, bus0.ovf} !== {4'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL arst_resume got %h/%b/%b want 1/0/0", bus0.out, bus0.tc, bus0.ovf);
    end
  endtask

  task automatic test_direction_toggle();
    logic       dir [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ens [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] eo0 [5] = '{4'd1, 4'd0, 4'd9, 4'd0, 4'd0};
    logic       et0 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] eo1 [5] = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd1};
    logic       et1 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       eov [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = ens[i]; up = dir[i];
      @(posedge clk); #1;
      checks++;
      if ({bus0.out, bus0.tc, bus0.ovf} !== {eo0[i], et0[i], eov[i]}) begin
        errors++; $display("FAIL dir_wrap[%0d] got %h/%b/%b want %h/%b/%b", i, bus0.out, bus0.tc, bus0.ovf, eo0[i], et0[i], eov[i]);
      end
      checks++;
      if ({bus1.out, bus1.tc, bus1.ovf} !== {eo1[i], et1[i], eov[i]}) begin
        errors++; $display("FAIL dir_sat[%0d] got %h/%b/%b want %h/%b/%b", i, bus1.out, bus1.tc, bus1.ovf, eo1[i], et1[i], eov[i]);
      end
    end
  endtask

  task automatic test_prescale();
    logic [3:0] eo [12] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [3:0] ef [3]  = '{4'd2, 4'd2, 4'd3};
    apply_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus0.out !== eo[i]) begin
        errors++; $display("FAIL prescale[%0d] got %h want %h", i, bus0.out, eo[i]);
      end
    end
    en = 1'b0;
    for (int i = 9; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus0.out !== eo[i]) begin
        errors++; $display("FAIL prescale_frz[%0d] got %h want %h", i, bus0.out, eo[i]);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus0.out !== ef[i]) begin
        errors++; $display("FAIL prescale_resume[%0d] got %h want %h", i, bus0.out, ef[i]);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`else
    test_count_up();
    test_count_down();
    test_load_clr();
    test_saturate();
    test_async_reset();
    test_direction_toggle();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised synchronous up/down counter; successor to the fixed 4-bit free-running counter.
- Generalises width and modulus; adds count enable, direction, synchronous clear/load, wrap-or-saturate mode, terminal-count pulse and sticky overflow flag.
- Used as the general event/timebase counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.
- PRESCALE, 4, enable divide ratio; only used when COUNTER_PRESCALE_EN is defined; must be >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear.
- load  input  1  synchronous load.
- load_val  input  WIDTH  value for load.
- out  output  WIDTH  registered count.
- tc  output  1  registered terminal-count pulse.
- ovf  output  1  sticky wrap/saturate flag.

Behaviour:
- Reset: rst low forces out=0, tc=0, ovf=0 immediately, regardless of clk, and holds them while low. The first edge after rst rises is evaluated normally.
- Per-edge priority: clr > load > count step > hold.
- clr=1: out=0, tc=0, ovf=0.
- load=1 (clr=0): out=load_val when load_val <= MODULUS-1, else out=MODULUS-1 (clamp); tc=0; ovf unchanged. load overrides any simultaneous en.
- Count step: occurs when en=1, clr=0 and load=0 (and the prescaler fires, if compiled in).
  - up=1, out < MODULUS-1: out+1.
  - up=0, out > 0: out-1.
- Terminal event: a count step taken while out is at the range end (MODULUS-1 going up, 0 going down).
  - SATURATE=0: out wraps (MODULUS-1 -> 0, 0 -> MODULUS-1).
  - SATURATE=1: out holds.
  - Either mode: tc=1 for exactly that one cycle (registered, visible one cycle after the triggering edge), and ovf sets.
- tc is 0 on every edge without a terminal event. Continuous terminal events (for example, held in saturation with en=1) give tc=1 on each such edge.
- ovf stays set until clr or reset.
- Direction change: takes effect on the same edge; up may toggle every cycle.
- Arithmetic is modulo MODULUS, never 2**WIDTH. out never exceeds MODULUS-1.
- Latency: one clk from input to out/tc.
- en=0: out, tc=0 and ovf hold.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler of width clog2(PRESCALE), minimum 1, counts cycles with en=1.
  - A count step occurs only on the en=1 edge where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - Reset, clr and load zero the prescaler.
  - en=0 freezes the prescaler.
  - PRESCALE=1 behaves as undefined.
- Undefined: no prescaler logic; every en=1 edge is a count step.

Test Plan (WIDTH=4, MODULUS=10, SATURATE=0 unless stated):
- Reset release, en=1, up=1 for 12 edges -> out 1..9, 0, 1, 2; tc=1 only in the cycle out=0 after 9; ovf=1 thereafter.
- Down count from reset, en=1, up=0 -> first edge out=9, tc=1, ovf=1; next edges 8, 7.
- load=1 with load_val=7 and en=1 on the same edge -> out=7, tc=0. Then load_val=14 -> out=9 (clamped). Then clr with load -> out=0, ovf=0.
- SATURATE=1, count up from 8 for 4 edges -> out 9, 9, 9, 9; tc=1 on the last 3 edges; ovf=1.
- Assert rst low mid-count (out=5) between edges -> out=0, tc=0, ovf=0 before the next clk edge; counting resumes from 0 after release.
- COUNTER_PRESCALE_EN defined, PRESCALE=4, en=1, up=1 -> out increments every 4th edge (0, 0, 0, 1, 1, 1, 1, 2...). en=0 mid-period freezes both prescaler and out.
